sr_latch_ctrl: RTL and testbench

//  Sequencer in front of sr_latch: converts single-cycle set/clear requests into

---
 rtl/sr_latch_ctrl.sv | 158 +++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl
//   Sequencer in front of an SR latch. It turns one-cycle set/clear requests
//   into fixed-width S or R pulses, and S and R are never high together. After
//   each pulse the outputs idle for a settle window. The latch feedback is then
//   checked. The result is either a one-cycle done pulse or a sticky error.
//
// Parameters
//   PULSE_W   cycles S or R is held high per operation (>=1)
//   SETTLE_W  cycles with S=R=0 before Q/Qbar are sampled (>=1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   set_req  in   one-cycle request: drive latch to Q=1
//   clr_req  in   one-cycle request: drive latch to Q=0 (wins over set_req)
//   err_clr  in   leaves ERROR and clears err; ignored in other states
//   Q_fb     in   latch Q feedback
//   Qbar_fb  in   latch Qbar feedback
//   S        out  latch set drive, registered
//   R        out  latch reset drive, registered
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse: operation completed and verified
//   err      out  sticky: feedback mismatch after settle
// -----------------------------------------------------------------------------
module sr_latch_ctrl #(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic err_clr,
  input  logic Q_fb,
  input  logic Qbar_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAX_W = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  // The counter is loaded with "cycles remaining minus one" on state entry.
  // It counts down to zero. It is only decremented when it is nonzero, so it
  // cannot wrap.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tgt;

  logic req_any;
  logic req_tgt;
  logic req_at_tgt;
  logic fb_ok;

  // clr_req wins when both requests arrive together, so the target is 1 only
  // when set_req is present without clr_req.
  assign req_any    = set_req | clr_req;
  assign req_tgt    = ~clr_req;
  // Q and Qbar must disagree for the latch to count as being at the target.
  // Q == Qbar is never treated as a valid state.
  assign req_at_tgt = (Q_fb == req_tgt) && (Qbar_fb != req_tgt);
  assign fb_ok      = (Q_fb == tgt)     && (Qbar_fb != tgt);

  // NOTE: all state and outputs are updated with non-blocking assignments in
  // one clocked block. Every register here is read in the same block, and this
  // keeps each read equal to the value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the counter and stored target, is
      // reset. S and R drop on reset assertion with no clock edge needed.
      state <= IDLE;
      cnt   <= '0;
      tgt   <= 1'b0;
      S     <= 1'b0;
      R     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (req_at_tgt) begin
              done <= 1'b1;
            end else begin
              state <= PULSE;
              cnt   <= PULSE_LOAD;
              tgt   <= req_tgt;
              S     <= req_tgt;
              R     <= ~req_tgt;
              busy  <= 1'b1;
            end
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            state <= SETTLE;
            cnt   <= SETTLE_LOAD;
            S     <= 1'b0;
            R     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            cnt <= '0;
            if (fb_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ERROR: begin
          if (err_clr) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          S     <= 1'b0;
          R     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_ctrl
//   Self-checking bench for sr_latch_ctrl with PULSE_W=2 and SETTLE_W=2. A
//   small latch model drives Q/Qbar from S/R. It can be made stuck, or made to
//   report Qbar equal to Q. Each scenario queues the expected per-cycle
//   {S,R,busy,done,err} values. These are compared #1 after each rising edge.
// -----------------------------------------------------------------------------
module tb_sr_latch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic set_req;
  logic clr_req;
  logic err_clr;
  logic Q_fb;
  logic Qbar_fb;
  logic S;
  logic R;
  logic busy;
  logic done;
  logic err;

  int total = 0;
  int bad   = 0;

  // Latch model
  logic q_model  = 1'b0;
  logic stuck    = 1'b0;
  logic qbar_bad = 1'b0;

  always @(posedge clk) begin
    if (!stuck) begin
      if (S)      q_model <= 1'b1;
      else if (R) q_model <= 1'b0;
    end
  end

  assign Q_fb    = q_model;
  assign Qbar_fb = qbar_bad ? q_model : ~q_model;

  sr_latch_ctrl #(
    .PULSE_W (2),
    .SETTLE_W(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_req(set_req),
    .clr_req(clr_req),
    .err_clr(err_clr),
    .Q_fb   (Q_fb),
    .Qbar_fb(Qbar_fb),
    .S      (S),
    .R      (R),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // S and R must never be high together, including during reset.
  always @(negedge clk) begin
    total++;
    if ((S & R) !== 1'b0) begin
      bad++;
      $display("FAIL sr_overlap at %0t: S=%b R=%b required S&R=0", $time, S, R);
    end
  end

  typedef struct packed {
    logic s;
    logic r;
    logic busy;
    logic done;
    logic err;
  } obs_t;

  obs_t exp_q[$];

  // Present requests on a falling edge, so the next rising edge samples them.
  task automatic start(input logic s, input logic c, input logic e);
    @(negedge clk);
    set_req = s;
    clr_req = c;
    err_clr = e;
  endtask

  // Pop one expectation per clock. Optionally inject a request after edge
  // number inj_idx+1.
  task automatic drain(input string tag, input int inj_idx = -1,
                       input logic inj_set = 1'b0, input logic inj_clr = 1'b0);
    int n;
    obs_t act;
    obs_t exp_v;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      set_req = 1'b0;
      clr_req = 1'b0;
      err_clr = 1'b0;
      if (i == inj_idx) begin
        set_req = inj_set;
        clr_req = inj_clr;
      end
      act   = {S, R, busy, done, err};
      exp_v = exp_q.pop_front();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d: got S,R,busy,done,err=%b required %b",
                 tag, i + 1, act, exp_v);
      end
    end
  endtask

  task automatic push_full(input logic tgt, input logic ends_in_err);
    obs_t drv;
    drv = tgt ? 5'b10100 : 5'b01100;
    exp_q.push_back(drv);
    exp_q.push_back(drv);
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b00100);
    if (ends_in_err) begin
      exp_q.push_back(5'b00101);
      exp_q.push_back(5'b00101);
    end else begin
      exp_q.push_back(5'b00010);
      exp_q.push_back(5'b00000);
    end
  endtask

  task automatic check_q(input string tag, input logic req);
    total++;
    if (Q_fb !== req) begin
      bad++;
      $display("FAIL %s: Q_fb=%b required %b", tag, Q_fb, req);
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    err_clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({S, R, busy, done, err} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_hold: got %b required 00000", {S, R, busy, done, err});
      end
    end
    rst_n = 1'b1;
    repeat (3) exp_q.push_back(5'b00000);
    drain("idle_after_reset");
  endtask

  task automatic test_set_pulse;
    start(1'b1, 1'b0, 1'b0);
    push_full(1'b1, 1'b0);
    drain("set_pulse");
    check_q("set_pulse_q", 1'b1);
  endtask

  task automatic test_clr_wins;
    start(1'b1, 1'b1, 1'b0);
    push_full(1'b0, 1'b0);
    drain("clr_wins");
    check_q("clr_wins_q", 1'b0);
  endtask

  task automatic test_already_there;
    start(1'b0, 1'b1, 1'b0);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00000);
    drain("already_clr");
    start(1'b1, 1'b0, 1'b0);
    push_full(1'b1, 1'b0);
    drain("set_again");
    start(1'b1, 1'b0, 1'b0);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00000);
    drain("already_set");
  endtask

  task automatic test_err_clr_exit(input string tag);
    start(1'b1, 1'b0, 1'b0);
    exp_q.push_back(5'b00101);
    exp_q.push_back(5'b00101);
    drain({tag, "_req_ignored"});
    start(1'b0, 1'b0, 1'b1);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    drain({tag, "_err_clr"});
  endtask

  task automatic test_stuck;
    start(1'b0, 1'b1, 1'b0);
    push_full(1'b0, 1'b0);
    drain("stuck_prep_clr");
    stuck = 1'b1;
    start(1'b1, 1'b0, 1'b0);
    push_full(1'b1, 1'b1);
    drain("stuck_set");
    test_err_clr_exit("stuck");
    stuck = 1'b0;
    start(1'b0, 1'b0, 1'b1);
    exp_q.push_back(5'b00000);
    drain("err_clr_in_idle");
  endtask

  task automatic test_qbar_equal;
    qbar_bad = 1'b1;
    start(1'b1, 1'b0, 1'b0);
    push_full(1'b1, 1'b1);
    drain("qbar_eq_q");
    qbar_bad = 1'b0;
    test_err_clr_exit("qbar_eq_q");
  endtask

  task automatic test_back_to_back;
    start(1'b0, 1'b1, 1'b0);
    push_full(1'b0, 1'b0);
    drain("drop_in_pulse", 0, 1'b1, 1'b0);
    start(1'b1, 1'b0, 1'b0);
    push_full(1'b1, 1'b0);
    drain("drop_in_settle", 2, 1'b0, 1'b1);
    check_q("back_to_back_q", 1'b1);
  endtask

  task automatic test_reset_mid_pulse;
    start(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    total++;
    if ({R, busy} !== 2'b11) begin
      bad++;
      $display("FAIL mid_pulse_pre: R,busy=%b required 11", {R, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({S, R, busy, done, err} !== 5'b00000) begin
      bad++;
      $display("FAIL mid_pulse_async: got %b required 00000", {S, R, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) exp_q.push_back(5'b00000);
    drain("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_set_pulse();
    test_clr_wins();
    test_already_there();
    test_stuck();
    test_qbar_equal();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
